// File: rtl/kid_motion.sv
// kid_motion: per-frame platformer physics for the kid's bounding box.
// Moves one pixel per step so that equality-based contact flags are never skipped.
module kid_motion #(
    parameter int START_L  = 300,
    parameter int START_T  = 500,
    parameter int KID_W    = 21,
    parameter int KID_H    = 21,
    parameter int H_SPEED  = 3,
    parameter int JUMP_V   = 8,
    parameter int MAX_FALL = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_jump,
    input  logic [3:0] is_collide,
    output logic [9:0] kid_t,
    output logic [9:0] kid_b,
    output logic [9:0] kid_l,
    output logic [9:0] kid_r,
    output logic       on_ground,
    output logic       facing,
    output logic       busy
);

    localparam int HW = $clog2(H_SPEED + 1);
    localparam logic signed [5:0] VMAX = 6'(MAX_FALL);
    localparam logic signed [5:0] VUP  = 6'(-JUMP_V);

    typedef enum logic [2:0] {
        IDLE, PHYS, HMOVE, HWAIT, VMOVE, VWAIT
    } state_t;

    state_t             state_q, state_d;
    logic [9:0]         kid_l_q, kid_l_d;
    logic [9:0]         kid_t_q, kid_t_d;
    logic signed [5:0]  vy_q, vy_d;
    logic [1:0]         jumps_q, jumps_d;
    logic [HW-1:0]      hcnt_q, hcnt_d;
    logic [5:0]         vcnt_q, vcnt_d;
    logic               facing_q, facing_d;
    logic               on_ground_q, on_ground_d;
    logic               jmp_s_q, jmp_s_d;
    logic               jmp_p_q, jmp_p_d;

    logic [10:0]        r_ext, b_ext;
    logic               at_right, at_bottom;
    logic               landed, jedge;
    logic [1:0]         jbase;

    function automatic logic [5:0] abs6(input logic signed [5:0] v);
        return v[5] ? (~v + 6'd1) : v;
    endfunction

    // Box geometry and screen-edge limits
    always_comb begin
        r_ext     = {1'b0, kid_l_q} + 11'(KID_W - 1);
        b_ext     = {1'b0, kid_t_q} + 11'(KID_H - 1);
        at_right  = r_ext >= 11'd1023;
        at_bottom = b_ext >= 11'd1023;
    end

    // Next-state and datapath updates for the physics FSM
    always_comb begin
        state_d     = state_q;
        kid_l_d     = kid_l_q;
        kid_t_d     = kid_t_q;
        vy_d        = vy_q;
        jumps_d     = jumps_q;
        hcnt_d      = hcnt_q;
        vcnt_d      = vcnt_q;
        facing_d    = facing_q;
        on_ground_d = on_ground_q;
        jmp_s_d     = jmp_s_q;
        jmp_p_d     = jmp_p_q;
        landed      = is_collide[1] && !vy_q[5];
        jedge       = jmp_s_q && !jmp_p_q;
        jbase       = landed ? 2'd2 : jumps_q;

        unique case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d = PHYS;
                    jmp_s_d = btn_jump;
                    jmp_p_d = jmp_s_q;
                end
            end
            PHYS: begin
                on_ground_d = is_collide[1];
                if (jedge && jbase != 2'd0) begin
                    vy_d    = VUP;
                    jumps_d = jbase - 2'd1;
                end else if (landed) begin
                    vy_d    = '0;
                    jumps_d = 2'd2;
                end else begin
                    vy_d = (vy_q >= VMAX) ? VMAX : vy_q + 6'sd1;
                end
                vcnt_d = abs6(vy_d);
                if (btn_left ^ btn_right) begin
                    hcnt_d   = HW'(H_SPEED);
                    facing_d = btn_left;
                end else begin
                    hcnt_d = '0;
                end
                state_d = HMOVE;
            end
            HMOVE: begin
                if (hcnt_q == '0) begin
                    state_d = VMOVE;
                end else if (facing_q ? (is_collide[2] || kid_l_q == 10'd0)
                                      : (is_collide[3] || at_right)) begin
                    hcnt_d = '0;
                end else begin
                    kid_l_d = facing_q ? kid_l_q - 10'd1 : kid_l_q + 10'd1;
                    hcnt_d  = hcnt_q - HW'(1);
                    state_d = HWAIT;
                end
            end
            HWAIT: state_d = HMOVE;
            VMOVE: begin
                if (vcnt_q == '0) begin
                    state_d = IDLE;
                end else if (vy_q[5]) begin
                    if (is_collide[0] || kid_t_q == 10'd0) begin
                        vy_d   = '0;
                        vcnt_d = '0;
                    end else begin
                        kid_t_d = kid_t_q - 10'd1;
                        vcnt_d  = vcnt_q - 6'd1;
                        state_d = VWAIT;
                    end
                end else begin
                    if (is_collide[1] || at_bottom) begin
                        vy_d        = '0;
                        vcnt_d      = '0;
                        on_ground_d = 1'b1;
                    end else begin
                        kid_t_d = kid_t_q + 10'd1;
                        vcnt_d  = vcnt_q - 6'd1;
                        state_d = VWAIT;
                    end
                end
            end
            VWAIT: state_d = VMOVE;
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset that aborts any update
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            kid_l_q     <= 10'(START_L);
            kid_t_q     <= 10'(START_T);
            vy_q        <= '0;
            jumps_q     <= 2'd2;
            hcnt_q      <= '0;
            vcnt_q      <= '0;
            facing_q    <= 1'b0;
            on_ground_q <= 1'b0;
            jmp_s_q     <= 1'b0;
            jmp_p_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            kid_l_q     <= kid_l_d;
            kid_t_q     <= kid_t_d;
            vy_q        <= vy_d;
            jumps_q     <= jumps_d;
            hcnt_q      <= hcnt_d;
            vcnt_q      <= vcnt_d;
            facing_q    <= facing_d;
            on_ground_q <= on_ground_d;
            jmp_s_q     <= jmp_s_d;
            jmp_p_q     <= jmp_p_d;
        end
    end

    assign kid_l     = kid_l_q;
    assign kid_t     = kid_t_q;
    assign kid_r     = kid_l_q + 10'(KID_W - 1);
    assign kid_b     = kid_t_q + 10'(KID_H - 1);
    assign on_ground = on_ground_q;
    assign facing    = facing_q;
    assign busy      = state_q != IDLE;

endmodule

// File: tb/tb_kid_motion.sv
// tb_kid_motion: directed checks of kid_motion against a simple
// equality-based collision environment.
module tb_kid_motion;

    logic       clk = 1'b0;
    logic       rst, tick, btn_left, btn_right, btn_jump;
    logic [3:0] is_collide;
    logic [9:0] kid_t, kid_b, kid_l, kid_r;
    logic       on_ground, facing, busy;

    int checks = 0;
    int errors = 0;

    logic floor_en, ceil_en, wall_en;
    int   floor_y = 578;
    int   ceil_y  = 480;
    int   wall_x  = 677;
    logic over;

    kid_motion dut (
        .clk(clk), .rst(rst), .tick(tick),
        .btn_left(btn_left), .btn_right(btn_right), .btn_jump(btn_jump),
        .is_collide(is_collide),
        .kid_t(kid_t), .kid_b(kid_b), .kid_l(kid_l), .kid_r(kid_r),
        .on_ground(on_ground), .facing(facing), .busy(busy)
    );

    always #5 clk = ~clk;

    // Environment: flags asserted when an edge sits exactly on a surface
    always_comb begin
        is_collide    = 4'b0000;
        is_collide[0] = ceil_en && (int'(kid_t) == ceil_y);
        is_collide[1] = floor_en && (int'(kid_b) == floor_y);
        is_collide[3] = wall_en && (int'(kid_r) == wall_x);
    end

    task automatic chk(input string tag,
                       input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("busy_timeout", busy, 0);
    endtask

    task automatic do_tick();
        @(negedge clk) tick = 1'b1;
        @(negedge clk) tick = 1'b0;
        wait_idle();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 0; tick = 0;
        btn_left = 0; btn_right = 0; btn_jump = 0;
        floor_en = 0; ceil_en = 0; wall_en = 0;
        over = 0;

        do_reset();
        chk("rst_kid_l", kid_l, 300);
        chk("rst_kid_t", kid_t, 500);
        chk("rst_kid_r", kid_r, 320);
        chk("rst_kid_b", kid_b, 520);
        chk("rst_busy", busy, 0);
        chk("rst_on_ground", on_ground, 0);
        chk("rst_facing", facing, 0);
        chk("rst_vy", $signed(dut.vy_q), 0);

        // Free fall onto a floor at 578
        floor_en = 1;
        repeat (11) do_tick();
        chk("fall_kid_b_mid", kid_b, 571);
        chk("fall_airborne", on_ground, 0);
        repeat (3) do_tick();
        chk("fall_kid_b", kid_b, 578);
        chk("fall_on_ground", on_ground, 1);
        chk("fall_vy", $signed(dut.vy_q), 0);

        // Ground jump
        btn_jump = 1;
        do_tick();
        chk("jump_kid_b_1", kid_b, 570);
        chk("jump_vy_1", $signed(dut.vy_q), -8);
        do_tick();
        chk("jump_kid_b_2", kid_b, 563);
        btn_jump = 0;
        repeat (20) do_tick();
        chk("jump_land_b", kid_b, 578);
        chk("jump_land_og", on_ground, 1);

        // Horizontal: left, then both held
        btn_left = 1;
        do_tick();
        chk("left_kid_l", kid_l, 297);
        chk("left_kid_r", kid_r, 317);
        chk("left_facing", facing, 1);
        btn_right = 1;
        do_tick();
        chk("both_kid_l", kid_l, 297);

        // Walk right into a wall at 677
        btn_left = 0;
        wall_en  = 1;
        for (int i = 0; i < 130; i++) begin
            do_tick();
            if (kid_r > 10'd677) over = 1;
        end
        chk("wall_kid_r", kid_r, 677);
        chk("wall_overrun", over, 0);
        chk("wall_facing", facing, 0);
        chk("wall_kid_b", kid_b, 578);
        btn_right = 0;
        wall_en   = 0;
        floor_en  = 0;

        // Ceiling at 480 during a rise from reset
        do_reset();
        ceil_en  = 1;
        btn_jump = 1;
        do_tick();
        chk("ceil_kid_t_1", kid_t, 492);
        btn_jump = 0;
        do_tick();
        chk("ceil_kid_t_2", kid_t, 485);
        do_tick();
        chk("ceil_stop", kid_t, 480);
        chk("ceil_vy", $signed(dut.vy_q), 0);
        do_tick();
        chk("ceil_next", kid_t, 481);
        ceil_en = 0;

        // Double jump: two mid-air edges accepted, third ignored
        do_reset();
        btn_jump = 1; do_tick();
        btn_jump = 0; do_tick();
        chk("dj_kid_t_2", kid_t, 485);
        btn_jump = 1; do_tick();
        chk("dj_kid_t_3", kid_t, 477);
        chk("dj_vy_3", $signed(dut.vy_q), -8);
        btn_jump = 0; do_tick();
        btn_jump = 1; do_tick();
        chk("dj_kid_t_5", kid_t, 464);
        chk("dj_vy_5", $signed(dut.vy_q), -6);
        btn_jump = 0;

        // Tick while busy is dropped
        @(negedge clk) tick = 1'b1;
        @(negedge clk) tick = 1'b0;
        @(negedge clk) chk("ovr_busy", busy, 1);
        tick = 1'b1;
        @(negedge clk) tick = 1'b0;
        wait_idle();
        repeat (4) @(negedge clk);
        chk("ovr_idle", busy, 0);
        chk("ovr_kid_t", kid_t, 459);
        chk("ovr_vy", $signed(dut.vy_q), -5);

        // Reset in the middle of an update
        btn_right = 1;
        @(negedge clk) tick = 1'b1;
        @(negedge clk) tick = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        btn_right = 0;
        chk("mid_kid_l", kid_l, 300);
        chk("mid_kid_t", kid_t, 500);
        chk("mid_busy_clr", busy, 0);
        chk("mid_vy", $signed(dut.vy_q), 0);
        repeat (3) @(negedge clk);
        chk("mid_stays_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
